// File: rtl/gcd_engine.sv
// gcd_engine
//   Subtractive-Euclid GCD unit with valid/ready operand and result
//   handshakes, zero-operand handling, a saturating subtract-step counter
//   and a synchronous abort.
//
//   Parameters
//     WIDTH     operand/result width in bits (>= 2)
//     CNT_W     iteration counter width; counter saturates at all-ones
//
//   Ports
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     in_valid   operand pair valid
//     in_ready   block can accept operands (IDLE and no abort)
//     in_a/in_b  unsigned operands, sampled only on the accept edge
//     abort      synchronous abort of the current operation
//     out_valid  result valid (DONE state)
//     out_ready  consumer accepts result
//     out_gcd    GCD result, held until the next completion
//     out_iter   number of subtract steps performed (saturating)
//     busy       high in CALC or DONE
module gcd_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_iter,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] oiter_q, oiter_d;

  // Datapath helpers evaluated on the registered operands.
  logic             a_zero;
  logic             b_zero;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             finish;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;
  logic [CNT_W-1:0] iter_inc;
  logic             accept;

  assign a_zero    = (a_q == '0);
  assign b_zero    = (b_q == '0);
  assign a_eq_b    = (a_q == b_q);
  assign a_gt_b    = (a_q > b_q);
  assign finish    = a_zero || b_zero || a_eq_b;
  // Only the difference with the larger operand as minuend is ever used,
  // so neither result can underflow where it is selected.
  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;
  // Saturate at all-ones; the computation itself keeps running.
  assign iter_inc  = (iter_q == '1) ? iter_q : iter_q + CNT_W'(1);

  // in_ready depends only on state and abort, never on in_valid.
  assign in_ready  = (state_q == S_IDLE) && !abort;
  assign accept    = in_valid && in_ready;

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_gcd   = gcd_q;
  assign out_iter  = oiter_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    iter_d  = iter_q;
    gcd_d   = gcd_q;
    oiter_d = oiter_q;

    if (abort) begin
      // Abort overrides every state, including a simultaneous result
      // handshake in DONE; the published result registers are kept.
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      iter_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            iter_d  = '0;
            state_d = S_CALC;
          end
        end

        S_CALC: begin
          if (finish) begin
            gcd_d   = a_zero ? b_q : a_q;
            oiter_d = iter_q;
            state_d = S_DONE;
          end else if (a_gt_b) begin
            a_d    = a_minus_b;
            iter_d = iter_inc;
          end else begin
            b_d    = b_minus_a;
            iter_d = iter_inc;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      iter_q  <= '0;
      gcd_q   <= '0;
      oiter_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      iter_q  <= iter_d;
      gcd_q   <= gcd_d;
      oiter_q <= oiter_d;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed cases, abort and reset
// corner cases, counter saturation on a narrow-counter instance, and
// random operand pairs against a quotient-based Euclid reference model.
module tb_gcd_engine;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [CNT_W-1:0] out_iter;
  logic             busy;

  // Narrow-counter instance for the saturation case.
  logic             s_in_valid;
  logic             s_in_ready;
  logic [WIDTH-1:0] s_in_a;
  logic [WIDTH-1:0] s_in_b;
  logic             s_abort;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [WIDTH-1:0] s_out_gcd;
  logic [3:0]       s_out_iter;
  logic             s_busy;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned last_g;

  gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_iter  (out_iter),
    .busy      (busy)
  );

  gcd_engine #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_a      (s_in_a),
    .in_b      (s_in_b),
    .abort     (s_abort),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_gcd   (s_out_gcd),
    .out_iter  (s_out_iter),
    .busy      (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: gcd by remainders, subtract count as the sum of Euclid
  // quotients, minus one on the final exact division (it stops at A==B).
  function automatic void ref_model(input int unsigned a0, input int unsigned b0,
                                    output int unsigned g, output int unsigned n);
    int unsigned a, b;
    a = a0;
    b = b0;
    n = 0;
    while (a != 0 && b != 0) begin
      if (a >= b) begin
        if (a % b == 0) begin
          n += a / b - 1;
          g = b;
          return;
        end
        n += a / b;
        a = a % b;
      end else begin
        if (b % a == 0) begin
          n += b / a - 1;
          g = a;
          return;
        end
        n += b / a;
        b = b % a;
      end
    end
    g = a + b;
  endfunction

  // Full transaction on the main instance; entered and left at a negedge.
  task automatic do_op(input int unsigned a, input int unsigned b,
                       input int unsigned hold, input string tag);
    int unsigned g, n, edges, exp_it;
    ref_model(a, b, g, n);
    exp_it = (n > 32'hFFFF) ? 32'hFFFF : n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && edges < n + 16) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, edges, n + 2);
    check({tag, "_gcd"}, 32'(out_gcd), g);
    check({tag, "_iter"}, 32'(out_iter), exp_it);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_gcd"}, 32'(out_gcd), g);
      check({tag, "_hold_iter"}, 32'(out_iter), exp_it);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    last_g = g;
  endtask

  initial begin
    int unsigned edges;
    n_checks   = 0;
    n_fail     = 0;
    last_g     = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    s_in_valid = 1'b0;
    s_in_a     = '0;
    s_in_b     = '0;
    s_abort    = 1'b0;
    s_out_ready = 1'b0;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_gcd", 32'(out_gcd), 32'd0);
    check("rst_out_iter", 32'(out_iter), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic and zero/equal cases.
    do_op(12, 8, 0, "basic_12_8");
    check("basic_iter_const", 32'(out_iter), 32'd2);
    do_op(0, 9, 0, "zero_a");
    do_op(7, 0, 0, "zero_b");
    do_op(0, 0, 0, "zero_both");
    do_op(5, 5, 0, "equal");

    // Backpressure: 10 cycles of out_ready low.
    do_op(48, 18, 10, "bp_48_18");

    // Reset mid-CALC clears the published result too.
    in_valid = 1'b1;
    in_a = 16'd12;
    in_b = 16'd8;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_gcd", 32'(out_gcd), 32'd0);
    check("midrst_out_iter", 32'(out_iter), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    last_g = 0;

    // Abort during CALC of (1000,1).
    do_op(21, 14, 0, "pre_abort");
    in_valid = 1'b1;
    in_a = 16'd1000;
    in_b = 16'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_calc_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_calc_busy", 32'(busy), 32'd0);
    check("abort_calc_in_ready", 32'(in_ready), 32'd1);
    check("abort_calc_keep_gcd", 32'(out_gcd), last_g);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_calc_no_valid", 32'(out_valid), 32'd0);
    end

    // Abort in DONE together with out_ready.
    in_valid = 1'b1;
    in_a = 16'd6;
    in_b = 16'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("abort_done_reached", 32'(out_valid), 32'd1);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_done_valid", 32'(out_valid), 32'd0);
    check("abort_done_busy", 32'(busy), 32'd0);
    check("abort_done_keep_gcd", 32'(out_gcd), 32'd2);
    check("abort_done_keep_iter", 32'(out_iter), 32'd2);

    // Abort with in_valid in IDLE: no accept.
    @(negedge clk);
    in_valid = 1'b1;
    abort = 1'b1;
    in_a = 16'd30;
    in_b = 16'd12;
    #1;
    check("abort_idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Saturating counter: (65535,1) with a 4-bit iteration counter.
    s_in_valid = 1'b1;
    s_in_a = 16'hFFFF;
    s_in_b = 16'd1;
    #1;
    check("sat_in_ready", 32'(s_in_ready), 32'd1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    s_in_valid = 1'b0;
    while (!s_out_valid && edges < 70000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("sat_latency", edges, 32'd65536);
    check("sat_gcd", 32'(s_out_gcd), 32'd1);
    check("sat_iter", 32'(s_out_iter), 32'd15);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("sat_post_valid", 32'(s_out_valid), 32'd0);

    // Random pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      int unsigned ra, rb, hold;
      ra = $urandom_range(0, 63);
      rb = $urandom_range(0, 63);
      hold = $urandom_range(0, 2);
      do_op(ra, rb, hold, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
